aes_round_seq: RTL and testbench
================================

AES_ROUND_SEQ -- requirements
Module: aes_round_seq

Interface
REQ-001 Parameter NR, default 10: number of AES rounds; the final round is round NR.
REQ-002 Parameter ROUND_LAT, default 2: clock cycles from rnd_state/rnd_key applied to rnd_result valid.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  requester offers a block.
REQ-006 in_ready  output  1  controller accepts a block.
REQ-007 in_block  input  128  plaintext block.
REQ-008 rk_idx  output  4  round-key index presented to the external key store.
REQ-009 rk_data  input  128  round key for rk_idx, combinational same-cycle return.
REQ-010 rnd_state  output  128  state driven into the shared round datapath.
REQ-011 rnd_key  output  128  key driven into the shared round datapath.
REQ-012 fin_sel  output  1  selects the final-round result over the full-round result.
REQ-013 rnd_result  input  128  muxed round-datapath output.
REQ-014 out_valid / out_ready / out_block  output / input / output  1 / 1 / 128  ciphertext handshake.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 FSM states SHALL be IDLE, RUN and DONE.
REQ-017 IDLE: in_ready=1 and rk_idx=0; on in_valid the block is accepted, state_reg <= in_block ^ rk_data, round <= 1, ph <= 0, next state RUN.
REQ-018 RUN: rnd_state=state_reg, rk_idx=round, rnd_key=rk_data, fin_sel=(round==NR); all are held stable for ROUND_LAT+1 cycles.
REQ-019 RUN phase counter ph counts 0..ROUND_LAT; at the edge ending ph==ROUND_LAT, state_reg <= rnd_result and ph <= 0.
REQ-020 At that same edge, round increments if round<NR; if round==NR, the next state is DONE.
REQ-021 Latency: out_valid rises exactly 1+NR*(ROUND_LAT+1) cycles after the accept edge (31 with the defaults).
REQ-022 DONE: out_valid=1 and out_block=state_reg; both are held unchanged until out_ready=1; on the out_ready edge, next state is IDLE.
REQ-023 in_ready SHALL be 0 in RUN and DONE; in_valid is ignored there, and a new block is accepted no earlier than the cycle after the DONE->IDLE edge.
REQ-024 out_valid SHALL be 0 outside DONE; out_block is don't-care outside DONE but driven from state_reg.
REQ-025 round is 4 bits and SHALL never exceed NR; ph SHALL never exceed ROUND_LAT.
REQ-026 rnd_result SHALL be sampled only on the edge ending ph==ROUND_LAT and ignored otherwise.

Reset
REQ-027 rst_n low SHALL force, asynchronously: state=IDLE, round=0, ph=0, state_reg=0, out_valid=0, busy=0, fin_sel=0.
REQ-028 Reset asserted mid-RUN or mid-DONE SHALL discard the block in flight with no output handshake; after release, in_ready=1 on the first cycle.

Structure
REQ-029 Shared package aes_pkg SHALL hold NR, ROUND_LAT defaults, the FSM state enum and the 128-bit block typedef.
REQ-030 No sub-module: FSM, round counter and phase counter SHALL live in aes_round_seq; the round datapath and key store stay external.

Verification
REQ-031 Bench SHALL model the round datapath with ROUND_LAT registers and a key store holding the FIPS-197 expanded key for key 000102030405060708090a0b0c0d0e0f.
REQ-032 Send in_block=00112233445566778899aabbccddeeff with out_ready=1 -> out_block=69c4e0d86a7b0430d8cdb78070b4c55a, with out_valid exactly 31 cycles after accept.
REQ-033 Hold out_ready=0 for 20 cycles at DONE -> out_valid and out_block stable, in_ready=0, in_valid ignored; output drains on out_ready=1.
REQ-034 Two back-to-back blocks with in_valid held high -> second accepted the cycle after DONE->IDLE; both ciphertexts correct.
REQ-035 Assert rst_n=0 at round 5, ph 1 -> all outputs at reset values immediately; next block after release gives correct ciphertext.
REQ-036 Check rk_idx sequence 0,1..10 and fin_sel=1 only during round 10 for all 3 cycles.

Source files
------------

// File: rtl/aes_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : aes_pkg
// Description : Shared definitions for the AES round sequencer: default
//               round count and round-datapath latency, the 128-bit block
//               type, the round-key index type and the controller FSM states.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

    localparam int c_nr_default        = 10;
    localparam int c_round_lat_default = 2;
    localparam int c_block_w           = 128;
    localparam int c_rk_idx_w          = 4;

    typedef logic [c_block_w-1:0]  block_t;
    typedef logic [c_rk_idx_w-1:0] rk_idx_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/aes_round_seq_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : aes_round_seq_if
// Description : Bundle of every non-clock signal of the AES round sequencer:
//               plaintext request handshake, key-store lookup, shared round
//               datapath drive/return, ciphertext handshake and busy flag.
// Modports    : master - requester/environment side (drives in_valid,
//                        in_block, rk_data, rnd_result, out_ready)
//               slave  - the sequencer itself
// Revision    : 1.0 - initial release
// ============================================================================
interface aes_round_seq_if;
    import aes_pkg::*;

    logic    in_valid;
    logic    in_ready;
    block_t  in_block;
    rk_idx_t rk_idx;
    block_t  rk_data;
    block_t  rnd_state;
    block_t  rnd_key;
    logic    fin_sel;
    block_t  rnd_result;
    logic    out_valid;
    logic    out_ready;
    block_t  out_block;
    logic    busy;

    modport master (
        output in_valid, in_block, rk_data, rnd_result, out_ready,
        input  in_ready, rk_idx, rnd_state, rnd_key, fin_sel,
               out_valid, out_block, busy
    );

    modport slave (
        input  in_valid, in_block, rk_data, rnd_result, out_ready,
        output in_ready, rk_idx, rnd_state, rnd_key, fin_sel,
               out_valid, out_block, busy
    );

endinterface
`default_nettype wire

// File: rtl/aes_round_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : aes_round_seq
// Description : Sequences one AES block through an external, shared,
//               fixed-latency round datapath. On accept the block is
//               whitened with round key 0; each of the NR rounds then holds
//               state/key/final-select stable for ROUND_LAT+1 cycles and
//               captures the datapath result on the last of them. The
//               ciphertext is held in DONE until the consumer takes it.
// Ports       : clk        - rising-edge clock
//               rst_n      - asynchronous active-low reset
//               bus.slave  - in_valid/in_ready/in_block   request
//                            rk_idx/rk_data               key-store lookup
//                            rnd_state/rnd_key/fin_sel    datapath drive
//                            rnd_result                   datapath return
//                            out_valid/out_ready/out_block result
//                            busy                         not idle
// Revision    : 1.0 - initial release
// ============================================================================
module aes_round_seq
    import aes_pkg::*;
#(
    parameter int NR        = c_nr_default,
    parameter int ROUND_LAT = c_round_lat_default
) (
    input logic            clk,
    input logic            rst_n,
    aes_round_seq_if.slave bus
);

    // Phase counter must hold 0..ROUND_LAT; keep at least one bit so a
    // zero-latency datapath still elaborates.
    localparam int                c_ph_w       = (ROUND_LAT < 1) ? 1 : $clog2(ROUND_LAT + 1);
    localparam rk_idx_t           c_last_round = rk_idx_t'(NR);
    localparam logic [c_ph_w-1:0] c_last_ph    = c_ph_w'(ROUND_LAT);

    state_e            r_state;
    state_e            w_state_nxt;
    block_t            r_block;
    rk_idx_t           r_round;
    logic [c_ph_w-1:0] r_ph;
    logic              w_round_end;

    // Last cycle of a round: the datapath result is valid and is captured.
    assign w_round_end = (r_state == RUN) && (r_ph == c_last_ph);

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and control outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        bus.in_ready  = 1'b0;
        bus.rk_idx    = '0;
        bus.fin_sel   = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b1;

        case (r_state)
            IDLE: begin
                // rk_idx stays 0 so rk_data is the whitening key on accept.
                bus.in_ready = 1'b1;
                bus.busy     = 1'b0;
                if (bus.in_valid) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                bus.rk_idx  = r_round;
                bus.fin_sel = (r_round == c_last_round);
                if (w_round_end && (r_round == c_last_round)) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Block register, round counter and phase counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_block <= '0;
            r_round <= '0;
            r_ph    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_block <= bus.in_block ^ bus.rk_data;
                        r_round <= rk_idx_t'(1);
                        r_ph    <= '0;
                    end
                end
                RUN: begin
                    if (r_ph == c_last_ph) begin
                        r_block <= bus.rnd_result;
                        r_ph    <= '0;
                        // Saturate at NR; the FSM leaves RUN on this edge.
                        if (r_round < c_last_round) begin
                            r_round <= r_round + rk_idx_t'(1);
                        end
                    end else begin
                        r_ph <= r_ph + c_ph_w'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Datapath drive is held constant for the whole round because r_block
    // and r_round only change on the round-ending edge.
    assign bus.rnd_state = r_block;
    assign bus.rnd_key   = bus.rk_data;
    assign bus.out_block = r_block;

endmodule
`default_nettype wire

// File: tb/tb_aes_round_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_aes_round_seq
// Description : Self-checking bench for aes_round_seq. Provides a key store
//               holding the AES-128 expanded key of 000102..0e0f and a
//               round datapath with ROUND_LAT register stages, and compares
//               the sequencer against a whole-block AES-128 reference.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_round_seq;
    import aes_pkg::*;

    localparam int NR        = 10;
    localparam int ROUND_LAT = 2;
    localparam int LAT       = 1 + NR * (ROUND_LAT + 1);

    typedef struct {
        logic [127:0] pt;
        logic [127:0] ct;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    aes_round_seq_if bus();

    aes_round_seq #(.NR(NR), .ROUND_LAT(ROUND_LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [7:0]   sbox [256];
    logic [127:0] rk   [11];
    logic [127:0] pipe [ROUND_LAT];
    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- AES reference arithmetic ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] sbox_calc(input logic [7:0] a);
        logic [7:0] inv;
        inv = 8'h00;
        for (int b = 1; b < 256; b++)
            if (gmul(a, 8'(b)) == 8'h01) inv = 8'(b);
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    // byte i of the state is row i%4, column i/4; byte 0 is the MSB
    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[127-8*(r+4*c) -: 8] = sbox[s[127-8*(r+4*((c+r)%4)) -: 8]];
        return o;
    endfunction

    function automatic logic [127:0] mix(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
            o[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
        return o;
    endfunction

    function automatic logic [127:0] round_fn(input logic [127:0] s, input logic [127:0] k, input logic fin);
        logic [127:0] t;
        t = sub_shift(s);
        if (!fin) t = mix(t);
        return t ^ k;
    endfunction

    function automatic logic [127:0] aes_encrypt(input logic [127:0] pt);
        logic [127:0] s;
        s = pt ^ rk[0];
        for (int r = 1; r < NR; r++) s = round_fn(s, rk[r], 1'b0);
        return round_fn(s, rk[NR], 1'b1);
    endfunction

    task automatic init_model();
        logic [31:0]  w [44];
        logic [31:0]  t;
        logic [7:0]   rc;
        logic [127:0] key;
        key = 128'h000102030405060708090a0b0c0d0e0f;
        for (int i = 0; i < 256; i++) sbox[i] = sbox_calc(8'(i));
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int k = 0; k <= NR; k++) rk[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
    endtask

    // ---------------- environment: key store + round datapath ----------------
    assign bus.rk_data = (bus.rk_idx <= 4'd10) ? rk[bus.rk_idx] : '0;

    always @(posedge clk) begin
        pipe[0] <= round_fn(bus.rnd_state, bus.rnd_key, bus.fin_sel);
        for (int i = 1; i < ROUND_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign bus.rnd_result = pipe[ROUND_LAT-1];

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] get_ctl();
        return {bus.rk_idx, bus.fin_sel, bus.in_ready, bus.out_valid, bus.busy};
    endfunction

    function automatic logic [3:0] get_done_ctl();
        return {bus.fin_sel, bus.in_ready, bus.out_valid, bus.busy};
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Offers pt, then walks every cycle up to the one where out_valid must
    // first rise, checking the round-key index, final-round select and
    // handshake flags, and finally the ciphertext. Returns in that DONE cycle.
    task automatic run_block(input logic [127:0] pt, input logic [127:0] exp_ct,
                             input bit hold_valid, input logic [127:0] next_pt);
        int guard;
        int r;
        bus.in_block = pt;
        bus.in_valid = 1'b1;
        guard = 0;
        while (!bus.in_ready && guard < 100) begin
            tick();
            guard++;
        end
        check("in_ready_idle", bus.in_ready, 1);
        check("idle_ctl", get_ctl(), 8'b0000_0100);
        check("idle_rnd_key", bus.rnd_key, rk[0]);
        tick();
        if (hold_valid) bus.in_block = next_pt;
        else            bus.in_valid = 1'b0;
        for (int cyc = 1; cyc < LAT; cyc++) begin
            r = (cyc - 1) / (ROUND_LAT + 1) + 1;
            check("run_ctl", get_ctl(), {4'(r), (r == NR), 1'b0, 1'b0, 1'b1});
            check("run_rnd_key", bus.rnd_key, rk[r]);
            tick();
        end
        check("done_ctl", get_done_ctl(), 4'b0011);
        check("ciphertext", bus.out_block, exp_ct);
    endtask

    // ---------------- test sequence ----------------
    vec_t vecs [6];

    initial begin
        logic [127:0] pa, pb, held;

        init_model();
        vecs[0] = '{pt: 128'h00112233445566778899aabbccddeeff,
                    ct: 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        for (int i = 1; i < 6; i++) begin
            vecs[i].pt = rand128();
            vecs[i].ct = aes_encrypt(vecs[i].pt);
        end

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_block  = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ctl", get_ctl(), 8'b0000_0100);
        check("reset_out_block", bus.out_block, 0);
        check("reset_rnd_state", bus.rnd_state, 0);
        rst_n = 1'b1;
        tick();
        check("post_reset_ctl", get_ctl(), 8'b0000_0100);

        // Table-driven vectors, consumer always ready.
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            run_block(vecs[i].pt, vecs[i].ct, 1'b0, '0);
            tick();
            check("drain_ctl", get_ctl(), 8'b0000_0100);
            repeat ($urandom_range(0, 3)) tick();
        end

        // Consumer stalls 20 cycles in DONE while new blocks are offered.
        bus.out_ready = 1'b0;
        pa = rand128();
        run_block(pa, aes_encrypt(pa), 1'b0, '0);
        held = aes_encrypt(pa);
        for (int i = 0; i < 20; i++) begin
            bus.in_valid = 1'b1;
            bus.in_block = rand128();
            tick();
            check("stall_ctl", get_done_ctl(), 4'b0011);
            check("stall_out_block", bus.out_block, held);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        check("stall_drain_ctl", get_ctl(), 8'b0000_0100);

        // Back-to-back with in_valid held high throughout.
        pa = rand128();
        pb = rand128();
        run_block(pa, aes_encrypt(pa), 1'b1, pb);
        tick();
        check("b2b_idle_ctl", get_ctl(), 8'b0000_0100);
        run_block(pb, aes_encrypt(pb), 1'b0, '0);
        tick();
        check("b2b_drain_ctl", get_ctl(), 8'b0000_0100);

        // Reset in round 5, phase 1.
        pa = rand128();
        bus.in_block = pa;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        repeat (13) tick();
        check("pre_reset_ctl", get_ctl(), 8'b0101_0001);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_ctl", get_ctl(), 8'b0000_0100);
        check("async_reset_out_block", bus.out_block, 0);
        check("async_reset_rnd_state", bus.rnd_state, 0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        tick();
        check("release_ctl", get_ctl(), 8'b0000_0100);
        pb = rand128();
        run_block(pb, aes_encrypt(pb), 1'b0, '0);
        tick();
        check("final_drain_ctl", get_ctl(), 8'b0000_0100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
